// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion
// and the write-side full comparison. Values are carried zero-extended in a
// fixed-width word so that one function set serves every pointer width.
package fifo_pkg;

  localparam int unsigned FN_W = 32;

  typedef logic [FN_W-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; upper zero bits leave the result unaffected.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = g;
    for (int unsigned s = 1; s < FN_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  // Full when the next write Gray pointer equals the synchronized read Gray
  // pointer with its two MSBs inverted.
  function automatic logic full_match(input word_t gray_next, input word_t rq2,
                                      input int unsigned addr_size);
    return gray_next == (rq2 ^ (word_t'(3) << (addr_size - 1)));
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and fifomem write-port bundle for the write-side
// controller. master = producers/fifomem side, slave = the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned data_Size    = 8,
  parameter int unsigned address_Size = 3,
  parameter int unsigned N_Req        = 4
);

  logic [N_Req-1:0]           req;
  logic [N_Req*data_Size-1:0] req_Data;
  logic [N_Req-1:0]           grant;
  logic                       w_Enable;
  logic [address_Size-1:0]    w_Addr;
  logic [data_Size-1:0]       write_Data;

  modport master (
    output req, req_Data,
    input  grant, w_Enable, w_Addr, write_Data
  );

  modport slave (
    input  req, req_Data,
    output grant, w_Enable, w_Addr, write_Data
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back capture stages, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: round-robin arbitration of the
// single fifomem write port between N_Req producers, binary/Gray write
// pointer, and registered full / almost-full flags derived from the
// synchronized read-domain Gray pointer.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned data_Size    = 8,
  parameter int unsigned address_Size = 3,
  parameter int unsigned N_Req        = 4,
  parameter int unsigned AF_Thresh    = 6
) (
  input  logic                  w_Clk,
  input  logic                  w_Rst_n,
  fifo_wr_arbiter_if.slave      bus,
  input  logic [address_Size:0] rd_Ptr_Gray,
  output logic                  fifo_Full,
  output logic                  w_Almost_Full,
  output logic [address_Size:0] w_Ptr_Gray
);

  localparam int unsigned PW = address_Size + 1;
  localparam int unsigned IW = (N_Req > 1) ? $clog2(N_Req) : 1;

  logic [PW-1:0]        w_ptr_bin;
  logic [PW-1:0]        bin_next;
  logic [PW-1:0]        gray_next;
  logic [PW-1:0]        rq2;
  logic [PW-1:0]        occupancy;
  logic                 full_next;
  logic                 almost_next;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        sel;
  logic [N_Req-1:0]     grant_c;
  logic [data_Size-1:0] data_c;
  logic                 found;
  logic                 w_en;
  int unsigned          idx;

  sync_2ff #(.WIDTH(PW)) u_rq_sync (
    .clk   (w_Clk),
    .rst_n (w_Rst_n),
    .d     (rd_Ptr_Gray),
    .q     (rq2)
  );

  // Round-robin search starting just after the last granted requester;
  // the first hit wins and later hits are ignored. Blocked while full.
  always_comb begin
    grant_c = '0;
    data_c  = '0;
    sel     = last_grant;
    found   = 1'b0;
    idx     = 0;
    if (!fifo_Full) begin
      for (int unsigned off = 1; off <= N_Req; off++) begin
        idx = (32'(last_grant) + off) % N_Req;
        if (!found && bus.req[idx]) begin
          found        = 1'b1;
          grant_c[idx] = 1'b1;
          sel          = IW'(idx);
          data_c       = bus.req_Data[idx*data_Size +: data_Size];
        end
      end
    end
  end

  assign w_en           = |grant_c;
  assign bus.grant      = grant_c;
  assign bus.w_Enable   = w_en;
  assign bus.w_Addr     = w_ptr_bin[address_Size-1:0];
  assign bus.write_Data = data_c;

  // Next-pointer and flag terms, computed on the post-write pointer.
  always_comb begin
    bin_next    = w_ptr_bin + PW'(w_en);
    gray_next   = PW'(bin2gray(word_t'(bin_next)));
    occupancy   = PW'(word_t'(bin_next) - gray2bin(word_t'(rq2)));
    almost_next = word_t'(occupancy) >= word_t'(AF_Thresh);
    full_next   = full_match(word_t'(gray_next), word_t'(rq2), address_Size);
  end

  // Binary and Gray write pointers advance together on each accepted word.
  always_ff @(posedge w_Clk or negedge w_Rst_n) begin
    if (!w_Rst_n) begin
      w_ptr_bin  <= '0;
      w_Ptr_Gray <= '0;
    end else begin
      w_ptr_bin  <= bin_next;
      w_Ptr_Gray <= gray_next;
    end
  end

  // Full and almost-full are re-evaluated every cycle so they clear once the
  // synchronized read pointer moves on.
  always_ff @(posedge w_Clk or negedge w_Rst_n) begin
    if (!w_Rst_n) begin
      fifo_Full     <= 1'b0;
      w_Almost_Full <= 1'b0;
    end else begin
      fifo_Full     <= full_next;
      w_Almost_Full <= almost_next;
    end
  end

  // Last-grant register; reset to N_Req-1 so requester 0 wins first.
  always_ff @(posedge w_Clk or negedge w_Rst_n) begin
    if (!w_Rst_n) begin
      last_grant <= IW'(N_Req - 1);
    end else if (w_en) begin
      last_grant <= sel;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters.
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] rd_gray;
  logic       full;
  logic       afull;
  logic [3:0] wgray;
  int         total = 0;
  int         bad = 0;

  logic [3:0] exp_g3 [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                             4'b0100, 4'b1000, 4'b0001, 4'b0100};
  logic [7:0] exp_d3 [9] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40,
                             8'h42, 8'h43, 8'h40, 8'h42};

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.data_Size(8), .address_Size(3), .N_Req(4)) bus ();

  fifo_wr_arbiter #(
    .data_Size    (8),
    .address_Size (3),
    .N_Req        (4),
    .AF_Thresh    (6)
  ) dut (
    .w_Clk         (clk),
    .w_Rst_n       (rst_n),
    .bus           (bus),
    .rd_Ptr_Gray   (rd_gray),
    .fifo_Full     (full),
    .w_Almost_Full (afull),
    .w_Ptr_Gray    (wgray)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    rd_gray = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req = '0;
    bus.req_Data = '0;
    rd_gray = '0;

    // 1: asynchronous reset, no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_wen", 32'(bus.w_Enable), 32'h0);
    check("rst_gray", 32'(wgray), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_afull", 32'(afull), 32'h0);
    check("rst_addr", 32'(bus.w_Addr), 32'h0);
    check("rst_wdata", 32'(bus.write_Data), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: fill from requester 0 with the reader idle
    for (int k = 0; k < 8; k++) begin
      bus.req = 4'b0001;
      bus.req_Data[7:0] = 8'(8'h10 + k);
      #1;
      check("fill_grant", 32'(bus.grant), 32'h1);
      check("fill_wen", 32'(bus.w_Enable), 32'h1);
      check("fill_addr", 32'(bus.w_Addr), 32'(k));
      check("fill_wdata", 32'(bus.write_Data), 32'(8'h10 + k));
      check("fill_full", 32'(full), 32'h0);
      check("fill_afull", 32'(afull), (k >= 6) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    #1;
    check("full_set", 32'(full), 32'h1);
    check("full_afull", 32'(afull), 32'h1);
    check("full_grant", 32'(bus.grant), 32'h0);
    check("full_wen", 32'(bus.w_Enable), 32'h0);
    check("full_gray", 32'(wgray), 32'hC);

    // 4: reader frees one slot; full clears on the 3rd edge
    rd_gray = 4'b0001;
    bus.req_Data[7:0] = 8'hAA;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      #1;
      check("rel_full", 32'(full), (e < 3) ? 32'h1 : 32'h0);
    end
    check("rel_grant", 32'(bus.grant), 32'h1);
    check("rel_addr", 32'(bus.w_Addr), 32'h0);
    check("rel_wdata", 32'(bus.write_Data), 32'hAA);
    check("rel_gray_pre", 32'(wgray), 32'hC);
    @(negedge clk);
    #1;
    check("rel_gray_post", 32'(wgray), 32'hD);
    check("rel_full_again", 32'(full), 32'h1);
    check("rel_grant_blk", 32'(bus.grant), 32'h0);

    // 3: round-robin with the reader keeping up
    do_reset();
    bus.req_Data = {8'h43, 8'h42, 8'h41, 8'h40};
    bus.req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) bus.req = 4'b1101;
      rd_gray = gray4(i);
      #1;
      check("rr_grant", 32'(bus.grant), 32'(exp_g3[i]));
      check("rr_wdata", 32'(bus.write_Data), 32'(exp_d3[i]));
      @(negedge clk);
    end

    // 6: reset in the middle of the burst
    rd_gray = gray4(9);
    #2 rst_n = 1'b0;
    rd_gray = '0;
    #1;
    check("mid_gray", 32'(wgray), 32'h0);
    check("mid_full", 32'(full), 32'h0);
    check("mid_afull", 32'(afull), 32'h0);
    check("mid_addr", 32'(bus.w_Addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    #1;
    check("mid_first", 32'(bus.grant), 32'h1);
    @(negedge clk);
    #1;
    check("mid_second", 32'(bus.grant), 32'h2);
    check("mid_addr1", 32'(bus.w_Addr), 32'h1);

    // 5: pointer wrap with the reader two writes behind
    do_reset();
    bus.req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      rd_gray = gray4((k >= 2) ? k - 2 : 0);
      bus.req_Data[7:0] = 8'(k);
      #1;
      check("wrap_gray", 32'(wgray), 32'(gray4(k % 16)));
      check("wrap_addr", 32'(bus.w_Addr), 32'(k % 8));
      check("wrap_full", 32'(full), 32'h0);
      check("wrap_grant", 32'(bus.grant), 32'h1);
      @(negedge clk);
    end
    #1;
    check("wrap_end_gray", 32'(wgray), 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
